// File: rtl/clock_pkg.sv
// clock_pkg: mode encoding and BCD field limits shared by the time-of-day logic.
package clock_pkg;
    typedef enum logic [1:0] {
        MODE_RUN     = 2'b00,
        MODE_SET_HR  = 2'b01,
        MODE_SET_MIN = 2'b10
    } mode_t;
    localparam logic [7:0] MAX_SEC = 8'h59;
    localparam logic [7:0] MAX_MIN = 8'h59;
    localparam logic [7:0] MAX_HR  = 8'h23;
endpackage

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter wrapping at MAX, with carry on the wrapping increment.
module bcd_mod_counter #(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    output logic [7:0] value,
    output logic       carry
);
    logic [7:0] nxt;
    always_comb nxt = (value == MAX) ? 8'h00 :
                      (value[3:0] == 4'd9) ? {value[7:4] + 4'd1, 4'd0} :
                      {value[7:4], value[3:0] + 4'd1};
    assign carry = en && value == MAX;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            value <= 8'h00;
        else if (clr)
            value <= 8'h00;
        else if (en)
            value <= nxt;
endmodule

// File: rtl/time_keeper.sv
// time_keeper: BCD time of day advanced by the 1 Hz tick, with key-driven hour/minute setting and auto-repeat.
module time_keeper
    import clock_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int REPEAT_DELAY = 2
) (
    input  logic       _1kHzIN,
    input  logic       Reset,
    input  logic       _1Hz,
    input  logic       ModeKey,
    input  logic       UpKey,
    output logic [7:0] Hour,
    output logic [7:0] Minute,
    output logic [7:0] Second,
    output logic [1:0] Mode,
    output logic       Tick
);
    logic [SYNC_STAGES-1:0] hz_sync, mode_sync, up_sync;
    logic       hz_d, mode_d, up_d;
    logic       hz_s, mode_s, up_s;
    logic       hz_rise, mode_rise, up_rise;
    logic [7:0] hold_cnt;
    mode_t      mode;
    logic       run, inc, sec_carry, min_carry, day_carry_unused;

    assign hz_s      = hz_sync[SYNC_STAGES-1];
    assign mode_s    = mode_sync[SYNC_STAGES-1];
    assign up_s      = up_sync[SYNC_STAGES-1];
    assign hz_rise   = hz_s & ~hz_d;
    assign mode_rise = mode_s & ~mode_d;
    assign up_rise   = up_s & ~up_d;
    assign run       = mode == MODE_RUN;
    // A mode change in the same cycle swallows any pending adjust increment
    assign inc  = ~run & ~mode_rise &
                  (up_rise | (up_s & Tick & hold_cnt == 8'(REPEAT_DELAY)));
    assign Mode = mode;

    always_ff @(posedge _1kHzIN or posedge Reset)
        if (Reset) begin
            hz_sync   <= '0;
            mode_sync <= '0;
            up_sync   <= '0;
            hz_d      <= 1'b0;
            mode_d    <= 1'b0;
            up_d      <= 1'b0;
            Tick      <= 1'b0;
            hold_cnt  <= 8'd0;
            mode      <= MODE_RUN;
        end else begin
            hz_sync   <= SYNC_STAGES'({hz_sync, _1Hz});
            mode_sync <= SYNC_STAGES'({mode_sync, ModeKey});
            up_sync   <= SYNC_STAGES'({up_sync, UpKey});
            hz_d      <= hz_s;
            mode_d    <= mode_s;
            up_d      <= up_s;
            Tick      <= hz_rise;
            hold_cnt  <= (!up_s || mode_rise) ? 8'd0 :
                         (Tick && hold_cnt != 8'(REPEAT_DELAY)) ? hold_cnt + 8'd1 : hold_cnt;
            mode      <= !mode_rise ? mode :
                         run ? MODE_SET_HR :
                         (mode == MODE_SET_HR) ? MODE_SET_MIN : MODE_RUN;
        end

    // Seconds hold at zero outside RUN; clear wins over a coincident tick but its carry still ripples
    bcd_mod_counter #(.MAX(MAX_SEC)) u_sec (
        .clk   (_1kHzIN),
        .rst   (Reset),
        .en    (run & Tick),
        .clr   (~run | mode_rise),
        .value (Second),
        .carry (sec_carry)
    );

    bcd_mod_counter #(.MAX(MAX_MIN)) u_min (
        .clk   (_1kHzIN),
        .rst   (Reset),
        .en    (run ? sec_carry : (mode == MODE_SET_MIN) & inc),
        .clr   (1'b0),
        .value (Minute),
        .carry (min_carry)
    );

    bcd_mod_counter #(.MAX(MAX_HR)) u_hr (
        .clk   (_1kHzIN),
        .rst   (Reset),
        .en    (run ? min_carry : (mode == MODE_SET_HR) & inc),
        .clr   (1'b0),
        .value (Hour),
        .carry (day_carry_unused)
    );
endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: randomized and directed checks of time_keeper against a seconds/minutes/hours model.
module tb_time_keeper;
    localparam int RD = 2;

    logic       clk = 1'b0;
    logic       Reset, _1Hz, ModeKey, UpKey;
    logic [7:0] Hour, Minute, Second;
    logic [1:0] Mode;
    logic       Tick;

    int checks = 0;
    int errors = 0;
    int tick_cnt = 0;
    int mh, mm, ms, mmode, held;
    bit up_held;

    time_keeper #(.SYNC_STAGES(2), .REPEAT_DELAY(RD)) dut (
        ._1kHzIN (clk),
        .Reset   (Reset),
        ._1Hz    (_1Hz),
        .ModeKey (ModeKey),
        .UpKey   (UpKey),
        .Hour    (Hour),
        .Minute  (Minute),
        .Second  (Second),
        .Mode    (Mode),
        .Tick    (Tick)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (Tick === 1'b1) tick_cnt++;

    function automatic logic [7:0] bcd(int v);
        return 8'((v / 10) * 16 + v % 10);
    endfunction

    function automatic logic [31:0] exp_state();
        return {bcd(mh), bcd(mm), bcd(ms), 6'd0, 2'(mmode)};
    endfunction

    function automatic void bump();
        if (mmode == 1) mh = (mh + 1) % 24;
        else if (mmode == 2) mm = (mm + 1) % 60;
    endfunction

    function automatic void model_reset();
        mh = 0; mm = 0; ms = 0; mmode = 0; held = 0;
    endfunction

    function automatic void model_tick();
        if (mmode == 0) begin
            ms++;
            if (ms == 60) begin
                ms = 0;
                mm++;
                if (mm == 60) begin
                    mm = 0;
                    mh = (mh + 1) % 24;
                end
            end
        end else if (up_held) begin
            if (held >= RD) bump();
            held++;
        end
    endfunction

    function automatic void model_mode();
        mmode = (mmode + 1) % 3;
        if (mmode == 1) ms = 0;
        held = 0;
    endfunction

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_hz();
        _1Hz = 1'b1; step(4);
        _1Hz = 1'b0; step(4);
        model_tick();
    endtask

    task automatic press_mode();
        ModeKey = 1'b1; step(4);
        ModeKey = 1'b0; step(4);
        model_mode();
    endtask

    task automatic press_up();
        UpKey = 1'b1; step(4);
        UpKey = 1'b0; step(4);
        bump();
    endtask

    task automatic test_reset();
        Reset = 1'b1; _1Hz = 1'b0; ModeKey = 1'b0; UpKey = 1'b0; up_held = 0;
        model_reset();
        step(3);
        checks++;
        if ({Hour, Minute, Second, Mode, Tick} !== 27'd0) begin
            errors++;
            $display("FAIL reset: got %h:%h:%h mode=%b tick=%b, want all zero", Hour, Minute, Second, Mode, Tick);
        end
        Reset = 1'b0;
        step(4);
    endtask

    task automatic test_run_61();
        tick_cnt = 0;
        for (int i = 0; i < 61; i++) begin
            pulse_hz();
            checks++;
            if ({Hour, Minute, Second, 6'd0, Mode} !== exp_state()) begin
                errors++;
                $display("FAIL run61[%0d]: got %h:%h:%h mode=%b, want %h", i, Hour, Minute, Second, Mode, exp_state());
            end
        end
        checks++;
        if (tick_cnt !== 61) begin
            errors++;
            $display("FAIL tick_count: got %0d, want 61", tick_cnt);
        end
    endtask

    task automatic test_wrap();
        press_mode();
        while (mh != 23) press_up();
        press_mode();
        while (mm != 59) press_up();
        press_mode();
        repeat (58) pulse_hz();
        for (int i = 0; i < 2; i++) begin
            pulse_hz();
            checks++;
            if ({Hour, Minute, Second, 6'd0, Mode} !== exp_state()) begin
                errors++;
                $display("FAIL wrap[%0d]: got %h:%h:%h mode=%b, want %h", i, Hour, Minute, Second, Mode, exp_state());
            end
        end
    endtask

    task automatic test_set_min_61();
        repeat (5) pulse_hz();
        press_mode();
        press_mode();
        checks++;
        if ({Hour, Minute, Second, 6'd0, Mode} !== exp_state()) begin
            errors++;
            $display("FAIL set_min_entry: got %h:%h:%h mode=%b, want %h", Hour, Minute, Second, Mode, exp_state());
        end
        repeat (61) press_up();
        checks++;
        if ({Hour, Minute, Second, 6'd0, Mode} !== exp_state()) begin
            errors++;
            $display("FAIL set_min_61: got %h:%h:%h mode=%b, want %h", Hour, Minute, Second, Mode, exp_state());
        end
        press_mode();
        checks++;
        if (Mode !== 2'b00) begin
            errors++;
            $display("FAIL set_min_exit: got mode=%b, want 00", Mode);
        end
    endtask

    task automatic test_repeat();
        press_mode();
        while (mh != 22) press_up();
        UpKey = 1'b1; step(6);
        bump(); up_held = 1; held = 0;
        for (int i = 0; i < 5; i++) begin
            pulse_hz();
            checks++;
            if ({Hour, Minute, Second, 6'd0, Mode} !== exp_state()) begin
                errors++;
                $display("FAIL repeat[%0d]: got %h:%h:%h mode=%b, want %h", i, Hour, Minute, Second, Mode, exp_state());
            end
        end
        UpKey = 1'b0; step(4);
        up_held = 0; held = 0;
        checks++;
        if (Hour !== 8'h02) begin
            errors++;
            $display("FAIL repeat_final: got hour=%h, want 02", Hour);
        end
    endtask

    task automatic test_mode_up_same();
        while (mh != 5) press_up();
        ModeKey = 1'b1; UpKey = 1'b1; step(4);
        ModeKey = 1'b0; UpKey = 1'b0; step(4);
        model_mode();
        checks++;
        if ({Hour, Minute, Second, 6'd0, Mode} !== exp_state() || Hour !== 8'h05 || Mode !== 2'b10) begin
            errors++;
            $display("FAIL mode_up_same: got %h:%h:%h mode=%b, want 05 mode 10", Hour, Minute, Second, Mode);
        end
        press_mode();
    endtask

    task automatic test_mode_tick_same();
        while (ms != 59) pulse_hz();
        _1Hz = 1'b1; step(1);
        ModeKey = 1'b1; step(4);
        _1Hz = 1'b0; ModeKey = 1'b0; step(4);
        model_tick();
        model_mode();
        checks++;
        if ({Hour, Minute, Second, 6'd0, Mode} !== exp_state()) begin
            errors++;
            $display("FAIL mode_tick_same: got %h:%h:%h mode=%b, want %h", Hour, Minute, Second, Mode, exp_state());
        end
        press_mode();
        press_mode();
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0: repeat ($urandom_range(1, 4)) pulse_hz();
                1: press_mode();
                2: press_up();
                default: begin
                    UpKey = 1'b1; step(6);
                    if (mmode != 0) bump();
                    up_held = 1; held = 0;
                    repeat ($urandom_range(0, 5)) pulse_hz();
                    UpKey = 1'b0; step(4);
                    up_held = 0; held = 0;
                end
            endcase
            checks++;
            if ({Hour, Minute, Second, 6'd0, Mode} !== exp_state()) begin
                errors++;
                $display("FAIL random[%0d]: got %h:%h:%h mode=%b, want %h", i, Hour, Minute, Second, Mode, exp_state());
            end
        end
    endtask

    task automatic test_async_reset();
        while (mmode != 0) press_mode();
        press_mode();
        while (mh != 12) press_up();
        press_mode();
        while (mm != 34) press_up();
        UpKey = 1'b1; step(6);
        bump();
        @(negedge clk);
        #2 Reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({Hour, Minute, Second, Mode, Tick} !== 27'd0) begin
            errors++;
            $display("FAIL async_reset: got %h:%h:%h mode=%b tick=%b, want all zero", Hour, Minute, Second, Mode, Tick);
        end
        step(2);
        Reset = 1'b0;
        step(8);
        up_held = 1;
        checks++;
        if ({Hour, Minute, Second, 6'd0, Mode} !== exp_state()) begin
            errors++;
            $display("FAIL post_reset_held: got %h:%h:%h mode=%b, want %h", Hour, Minute, Second, Mode, exp_state());
        end
        repeat (2) pulse_hz();
        checks++;
        if ({Hour, Minute, Second, 6'd0, Mode} !== exp_state()) begin
            errors++;
            $display("FAIL post_reset_ticks: got %h:%h:%h mode=%b, want %h", Hour, Minute, Second, Mode, exp_state());
        end
        UpKey = 1'b0; step(4);
        up_held = 0;
    endtask

    initial begin
        test_reset();
        test_run_61();
        test_wrap();
        test_set_min_61();
        test_repeat();
        test_mode_up_same();
        test_mode_tick_same();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
